// File: rtl/match_sequencer.sv
// Match sequencer for a two-player paddle game: serve hold, rally goal detection, scoring and game over.
// Defining the PAUSE_EN macro adds a PAUSED state toggled by rising edges of the pause button.
module match_sequencer #(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 200,
    parameter int GOAL_L      = 10,
    parameter int GOAL_R      = 630
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] ballx1,
    input  logic [9:0] ballx2,
    output logic       ball_rst,
    output logic       move_en,
    output logic       serve_dir,
    output logic [3:0] p1score,
    output logic [3:0] p2score,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);
    localparam int            CW       = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_TICKS - 1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
    localparam logic [9:0]    GOAL_LX  = 10'(GOAL_L);
    localparam logic [9:0]    GOAL_RX  = 10'(GOAL_R);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        RALLY    = 3'd2,
        POINT    = 3'd3,
        PAUSED   = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    p1_q, p1_d;
    logic [3:0]    p2_q, p2_d;
    logic          dir_q, dir_d;
    logic          win_q, win_d;
    logic          start_prev_q;
    logic          start_edge_s;

`ifdef PAUSE_EN
    logic          pause_prev_q;
    logic          pause_edge_s;
    logic          saved_rally_q, saved_rally_d;
    assign pause_edge_s = pause & ~pause_prev_q;
`else
    logic          unused_pause_s;
    assign unused_pause_s = pause;
`endif

    assign start_edge_s = start & ~start_prev_q;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s < WIN) ? s + 4'd1 : s;
    endfunction

    // Next-state, serve counter and score update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;
        win_d   = win_q;
`ifdef PAUSE_EN
        saved_rally_d = saved_rally_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_edge_s) begin
                    state_d = SERVE;
                    cnt_d   = {CW{1'b0}};
                    dir_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
`ifdef PAUSE_EN
                if (pause_edge_s) begin
                    saved_rally_d = 1'b0;
                    state_d       = PAUSED;
                end else
`endif
                if (tick && (cnt_q == CNT_LAST)) begin
                    state_d = RALLY;
                    cnt_d   = {CW{1'b0}};
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1'b1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            // Left goal is tested first so it wins a simultaneous double goal
            RALLY: begin
                if (ballx1 <= GOAL_LX) begin
                    p2_d    = sat_inc(p2_q);
                    dir_d   = 1'b0;
                    state_d = POINT;
                end else if (ballx2 >= GOAL_RX) begin
                    p1_d    = sat_inc(p1_q);
                    dir_d   = 1'b1;
                    state_d = POINT;
                end
`ifdef PAUSE_EN
                else if (pause_edge_s) begin
                    saved_rally_d = 1'b1;
                    state_d       = PAUSED;
                end
`endif
                else begin
                    state_d = RALLY;
                end
            end
            POINT: begin
                if ((p1_q == WIN) || (p2_q == WIN)) begin
                    state_d = GAMEOVER;
                    win_d   = (p2_q == WIN);
                end else begin
                    state_d = SERVE;
                    cnt_d   = {CW{1'b0}};
                end
            end
            GAMEOVER: begin
                if (start_edge_s) begin
                    state_d = SERVE;
                    cnt_d   = {CW{1'b0}};
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    dir_d   = 1'b0;
                    win_d   = 1'b0;
                end else begin
                    state_d = GAMEOVER;
                end
            end
`ifdef PAUSE_EN
            PAUSED: begin
                if (pause_edge_s) begin
                    state_d = saved_rally_q ? RALLY : SERVE;
                end else begin
                    state_d = PAUSED;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
                p1_d    = 4'd0;
                p2_d    = 4'd0;
                dir_d   = 1'b0;
                win_d   = 1'b0;
            end
        endcase
    end

    // State, score and edge-detect registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CW{1'b0}};
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            dir_q        <= 1'b0;
            win_q        <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef PAUSE_EN
            pause_prev_q  <= 1'b0;
            saved_rally_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            dir_q        <= dir_d;
            win_q        <= win_d;
            start_prev_q <= start;
`ifdef PAUSE_EN
            pause_prev_q  <= pause;
            saved_rally_q <= saved_rally_d;
`endif
        end
    end

    // Ball/paddle controls decoded from the registered state only
    always_comb begin
        ball_rst  = 1'b1;
        move_en   = 1'b0;
        game_over = 1'b0;
        case (state_q)
            RALLY: begin
                ball_rst = 1'b0;
                move_en  = 1'b1;
            end
            GAMEOVER: game_over = 1'b1;
`ifdef PAUSE_EN
            PAUSED:   ball_rst = ~saved_rally_q;
`endif
            default:  ball_rst = 1'b1;
        endcase
    end

    assign state     = state_q;
    assign p1score   = p1_q;
    assign p2score   = p2_q;
    assign serve_dir = dir_q;
    assign winner    = win_q;
endmodule

// File: tb/tb_match_sequencer.sv
// Randomized self-checking bench for match_sequencer: expectations come from counted ticks,
// goal rules applied to the driven ball coordinates, and a plain integer score model.
module tb_match_sequencer;
    localparam int WIN     = 3;
    localparam int SERVE_T = 200;
    localparam int GL      = 10;
    localparam int GR      = 630;
`ifdef PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clk;
    logic       reset, tick, start, pause;
    logic [9:0] ballx1, ballx2;
    logic       ball_rst, move_en, serve_dir, game_over, winner;
    logic [3:0] p1score, p2score;
    logic [2:0] state;

    int   checks = 0;
    int   passes = 0;
    int   p1_m   = 0;
    int   p2_m   = 0;
    logic dir_m  = 1'b0;

    match_sequencer #(
        .WIN_SCORE  (WIN),
        .SERVE_TICKS(SERVE_T),
        .GOAL_L     (GL),
        .GOAL_R     (GR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .ballx1   (ballx1),
        .ballx2   (ballx2),
        .ball_rst (ball_rst),
        .move_en  (move_en),
        .serve_dir(serve_dir),
        .p1score  (p1score),
        .p2score  (p2score),
        .game_over(game_over),
        .winner   (winner),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic safe_ball();
        ballx1 = 10'($urandom_range(GL + 1, 1023));
        ballx2 = 10'($urandom_range(0, GR - 1));
    endtask

    task automatic press_start();
        start = 1'b0;
        tick  = ($urandom_range(0, 1) != 0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // From the first SERVE cycle, drive random ticks until SERVE_T ticks have been seen
    task automatic serve_phase();
        int n = 0;
        int cyc = 0;
        logic [2:0] exp_st;
        while (n < SERVE_T && cyc < 4000) begin
            tick   = ($urandom_range(0, 2) != 0);
            start  = 1'($urandom_range(0, 1));
            pause  = 1'b0;
            ballx1 = 10'($urandom_range(0, 1023));
            ballx2 = 10'($urandom_range(0, 1023));
            step();
            if (tick) n++;
            cyc++;
            exp_st = (n < SERVE_T) ? 3'd1 : 3'd2;
            checks++;
            if ({state, ball_rst, move_en, serve_dir, game_over, p1score, p2score} !==
                {exp_st, exp_st == 3'd1, exp_st == 3'd2, dir_m, 1'b0, 4'(p1_m), 4'(p2_m)})
                $display("FAIL serve ticks=%0d got st=%0d br=%b me=%b dir=%b go=%b p=%0d/%0d want st=%0d dir=%b p=%0d/%0d",
                         n, state, ball_rst, move_en, serve_dir, game_over, p1score, p2score, exp_st, dir_m, p1_m, p2_m);
            else passes++;
        end
        tick  = 1'b0;
        start = 1'b0;
        safe_ball();
    endtask

    // From RALLY: some quiet rally cycles, then one goal cycle with the given coordinates
    task automatic rally_goal(input logic [9:0] gx1, input logic [9:0] gx2);
        int idle = $urandom_range(0, 12);
        for (int i = 0; i < idle; i++) begin
            tick  = ($urandom_range(0, 1) != 0);
            start = 1'($urandom_range(0, 1));
            safe_ball();
            step();
            checks++;
            if ({state, ball_rst, move_en, p1score, p2score} !== {3'd2, 1'b0, 1'b1, 4'(p1_m), 4'(p2_m)})
                $display("FAIL rally_quiet got st=%0d br=%b me=%b p=%0d/%0d want st=2 br=0 me=1 p=%0d/%0d",
                         state, ball_rst, move_en, p1score, p2score, p1_m, p2_m);
            else passes++;
        end
        tick   = 1'b0;
        start  = 1'b0;
        ballx1 = gx1;
        ballx2 = gx2;
        if (int'(gx1) <= GL) begin
            p2_m  = (p2_m < WIN) ? p2_m + 1 : p2_m;
            dir_m = 1'b0;
        end else if (int'(gx2) >= GR) begin
            p1_m  = (p1_m < WIN) ? p1_m + 1 : p1_m;
            dir_m = 1'b1;
        end
        step();
        checks++;
        if ({state, ball_rst, move_en, serve_dir, p1score, p2score} !==
            {3'd3, 1'b1, 1'b0, dir_m, 4'(p1_m), 4'(p2_m)})
            $display("FAIL goal x1=%0d x2=%0d got st=%0d br=%b me=%b dir=%b p=%0d/%0d want st=3 dir=%b p=%0d/%0d",
                     gx1, gx2, state, ball_rst, move_en, serve_dir, p1score, p2score, dir_m, p1_m, p2_m);
        else passes++;
        safe_ball();
        step();
        if (p1_m == WIN || p2_m == WIN) begin
            checks++;
            if ({state, game_over, winner, ball_rst, move_en} !== {3'd5, 1'b1, 1'(p2_m == WIN), 1'b1, 1'b0})
                $display("FAIL after_point_gameover got st=%0d go=%b win=%b br=%b me=%b want st=5 go=1 win=%b",
                         state, game_over, winner, ball_rst, move_en, p2_m == WIN);
            else passes++;
        end else begin
            checks++;
            if ({state, game_over, ball_rst, move_en} !== {3'd1, 1'b0, 1'b1, 1'b0})
                $display("FAIL after_point_serve got st=%0d go=%b br=%b me=%b want st=1 go=0 br=1 me=0",
                         state, game_over, ball_rst, move_en);
            else passes++;
        end
    endtask

    task automatic random_goal();
        int kind = $urandom_range(0, 2);
        logic [9:0] gx1, gx2;
        gx1 = (kind != 1) ? 10'($urandom_range(0, GL)) : 10'($urandom_range(GL + 1, 1023));
        gx2 = (kind != 0) ? 10'($urandom_range(GR, 1023)) : 10'($urandom_range(0, GR - 1));
        rally_goal(gx1, gx2);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tick = 1'b1; pause = 1'b1;
        ballx1 = 10'd0; ballx2 = 10'd1023;
        step();
        step();
        checks++;
        if ({state, ball_rst, move_en, serve_dir, p1score, p2score, game_over, winner} !==
            {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_state got st=%0d br=%b me=%b dir=%b p=%0d/%0d go=%b win=%b want idle defaults",
                     state, ball_rst, move_en, serve_dir, p1score, p2score, game_over, winner);
        else passes++;
        // start held through reset counts as a fresh edge once reset drops
        reset = 1'b0; pause = 1'b0; tick = 1'b0;
        step();
        checks++;
        if ({state, ball_rst, move_en} !== {3'd1, 1'b1, 1'b0})
            $display("FAIL reset_history got st=%0d br=%b me=%b want st=1 br=1 me=0", state, ball_rst, move_en);
        else passes++;
        reset = 1'b1;
        step();
        checks++;
        if (state !== 3'd0) $display("FAIL reset_from_serve got st=%0d want 0", state);
        else passes++;
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = ($urandom_range(0, 1) != 0);
            step();
            checks++;
            if ({state, ball_rst, move_en} !== {3'd0, 1'b1, 1'b0})
                $display("FAIL idle_hold got st=%0d br=%b me=%b want st=0 br=1 me=0", state, ball_rst, move_en);
            else passes++;
        end
    endtask

    task automatic test_serve_timing();
        p1_m = 0; p2_m = 0; dir_m = 1'b0;
        press_start();
        checks++;
        if ({state, p1score, p2score, serve_dir, ball_rst, move_en} !== {3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL start_to_serve got st=%0d p=%0d/%0d dir=%b br=%b me=%b want st=1 p=0/0 dir=0 br=1 me=0",
                     state, p1score, p2score, serve_dir, ball_rst, move_en);
        else passes++;
        serve_phase();
    endtask

    task automatic test_goal_boundaries();
        ballx1 = 10'(GL + 1);
        ballx2 = 10'(GR - 1);
        step();
        checks++;
        if ({state, p1score, p2score} !== {3'd2, 4'(p1_m), 4'(p2_m)})
            $display("FAIL near_goal got st=%0d p=%0d/%0d want st=2 p=%0d/%0d", state, p1score, p2score, p1_m, p2_m);
        else passes++;
        rally_goal(10'd100, 10'd630);
        serve_phase();
        rally_goal(10'd10, 10'd300);
        serve_phase();
        rally_goal(10'd5, 10'd635);
        serve_phase();
        rally_goal(10'd200, 10'd631);
        serve_phase();
    endtask

    task automatic test_reset_mid_rally();
        reset = 1'b1; tick = 1'b1; start = 1'b1;
        ballx1 = 10'd5; ballx2 = 10'd700;
        step();
        checks++;
        if ({state, p1score, p2score, ball_rst, move_en, serve_dir} !== {3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_mid_rally got st=%0d p=%0d/%0d br=%b me=%b dir=%b want st=0 p=0/0 br=1 me=0 dir=0",
                     state, p1score, p2score, ball_rst, move_en, serve_dir);
        else passes++;
        reset = 1'b0; start = 1'b0; tick = 1'b0;
        safe_ball();
        p1_m = 0; p2_m = 0; dir_m = 1'b0;
    endtask

    task automatic check_restart(input string name);
        checks++;
        if ({state, p1score, p2score, serve_dir, game_over, winner} !== {3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL %s got st=%0d p=%0d/%0d dir=%b go=%b win=%b want st=1 p=0/0 dir=0 go=0 win=0",
                     name, state, p1score, p2score, serve_dir, game_over, winner);
        else passes++;
        p1_m = 0; p2_m = 0; dir_m = 1'b0;
    endtask

    task automatic test_p1_wins();
        press_start();
        check_restart("p1_match_start");
        for (int g = 0; g < WIN; g++) begin
            serve_phase();
            rally_goal(10'($urandom_range(GL + 1, 1023)), 10'($urandom_range(GR, 1023)));
        end
        for (int i = 0; i < 4; i++) begin
            tick   = ($urandom_range(0, 1) != 0);
            ballx1 = 10'($urandom_range(0, GL));
            ballx2 = 10'($urandom_range(GR, 1023));
            step();
            checks++;
            if ({state, game_over, winner, p1score, p2score} !== {3'd5, 1'b1, 1'b0, 4'(WIN), 4'd0})
                $display("FAIL gameover_frozen got st=%0d go=%b win=%b p=%0d/%0d want st=5 go=1 win=0 p=%0d/0",
                         state, game_over, winner, p1score, p2score, WIN);
            else passes++;
        end
        safe_ball();
        press_start();
        check_restart("gameover_restart");
    endtask

    task automatic test_random_match();
        for (int m = 0; m < 2; m++) begin
            int pts = 0;
            while (p1_m != WIN && p2_m != WIN && pts < 2 * WIN) begin
                serve_phase();
                random_goal();
                pts++;
            end
            press_start();
            check_restart("random_match_restart");
        end
    endtask

    // Drive until count ticks have been issued; ticks advance the serve count only when not frozen
    task automatic serve_ticks_checked(input int count, inout int n, input bit frozen);
        int issued = 0;
        logic [2:0] exp_st;
        while (issued < count) begin
            tick   = ($urandom_range(0, 2) != 0);
            ballx1 = 10'($urandom_range(0, 1023));
            ballx2 = 10'($urandom_range(0, 1023));
            step();
            if (tick) begin
                issued++;
                if (!frozen) n++;
            end
            exp_st = frozen ? 3'd4 : ((n < SERVE_T) ? 3'd1 : 3'd2);
            checks++;
            if ({state, ball_rst, move_en} !== {exp_st, exp_st != 3'd2, exp_st == 3'd2})
                $display("FAIL pause_serve n=%0d got st=%0d br=%b me=%b want st=%0d", n, state, ball_rst, move_en, exp_st);
            else passes++;
        end
        tick = 1'b0;
        safe_ball();
    endtask

    task automatic pulse_pause();
        tick  = 1'b0;
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic test_pause();
        int n = 0;
        bit frozen = 1'b0;
        serve_ticks_checked(50, n, frozen);
        pulse_pause();
        frozen = PAUSE_ON;
        checks++;
        if ({state, ball_rst, move_en} !== {(frozen ? 3'd4 : 3'd1), 1'b1, 1'b0})
            $display("FAIL pause_in_serve got st=%0d br=%b me=%b want st=%0d br=1 me=0",
                     state, ball_rst, move_en, frozen ? 4 : 1);
        else passes++;
        serve_ticks_checked(100, n, frozen);
        pulse_pause();
        frozen = 1'b0;
        checks++;
        if (state !== 3'd1) $display("FAIL resume_serve got st=%0d want 1", state);
        else passes++;
        serve_ticks_checked(SERVE_T - n, n, frozen);
        pulse_pause();
        frozen = PAUSE_ON;
        checks++;
        if ({state, ball_rst, move_en} !== {(frozen ? 3'd4 : 3'd2), 1'b0, !frozen})
            $display("FAIL pause_in_rally got st=%0d br=%b me=%b want st=%0d br=0 me=%b",
                     state, ball_rst, move_en, frozen ? 4 : 2, !frozen);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            tick = ($urandom_range(0, 1) != 0);
            if (frozen) begin
                ballx1 = 10'($urandom_range(0, GL));
                ballx2 = 10'($urandom_range(GR, 1023));
            end else begin
                safe_ball();
            end
            step();
            checks++;
            if ({state, p1score, p2score} !== {(frozen ? 3'd4 : 3'd2), 4'(p1_m), 4'(p2_m)})
                $display("FAIL paused_goal_frozen got st=%0d p=%0d/%0d want st=%0d p=%0d/%0d",
                         state, p1score, p2score, frozen ? 4 : 2, p1_m, p2_m);
            else passes++;
        end
        safe_ball();
        pulse_pause();
        frozen = 1'b0;
        checks++;
        if ({state, move_en, ball_rst} !== {3'd2, 1'b1, 1'b0})
            $display("FAIL resume_rally got st=%0d me=%b br=%b want st=2 me=1 br=0", state, move_en, ball_rst);
        else passes++;
        pulse_pause();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({state, ball_rst, move_en, p1score, p2score, game_over} !== {3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0})
            $display("FAIL reset_from_pause got st=%0d br=%b me=%b p=%0d/%0d go=%b want idle", state, ball_rst,
                     move_en, p1score, p2score, game_over);
        else passes++;
        pulse_pause();
        step();
        checks++;
        if (state !== 3'd0) $display("FAIL pause_in_idle got st=%0d want 0", state);
        else passes++;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0;
        ballx1 = 10'd320; ballx2 = 10'd328;
        test_reset();
        test_serve_timing();
        test_goal_boundaries();
        test_reset_mid_rally();
        test_p1_wins();
        test_random_match();
        test_pause();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
